cache_byte_valid_ctrl: RTL

CACHE_BYTE_VALID_CTRL -- requirements
Module: cache_byte_valid_ctrl

---
 rtl/cache_byte_valid_ctrl_if.sv | 35 +++
 rtl/cache_byte_valid_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cache_byte_valid_ctrl_if.sv
// Request/response bundle for the byte-valid controller: read, update and invalidate channels.
interface cache_byte_valid_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned WAYS       = 4,
   parameter int unsigned WORD_BYTES = 4
);
   localparam int unsigned WAY_W = $clog2(WAYS);

   logic                       rd_en;
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic [WAY_W-1:0]           rd_way;
   logic                       rd_valid;
   logic [WORD_BYTES-1:0]      rd_mask;
   logic [WAYS*WORD_BYTES-1:0] rd_mask_all;

   logic                       upd_en;
   logic [ADDR_WIDTH-1:0]      upd_addr;
   logic [WAY_W-1:0]           upd_way;
   logic [WORD_BYTES-1:0]      upd_mask;
   logic                       upd_clr;

   logic                       inv_req;
   logic                       busy;
   logic                       inv_done;

   modport master (
      output rd_en, rd_addr, rd_way, upd_en, upd_addr, upd_way, upd_mask, upd_clr, inv_req,
      input  rd_valid, rd_mask, rd_mask_all, busy, inv_done
   );

   modport slave (
      input  rd_en, rd_addr, rd_way, upd_en, upd_addr, upd_way, upd_mask, upd_clr, inv_req,
      output rd_valid, rd_mask, rd_mask_all, busy, inv_done
   );
endinterface

// File: rtl/cache_byte_valid_ctrl.sv
// Per-way byte-valid flag store with read-modify-write update pipeline and an
// invalidate-all sweep that zeroes one index per cycle.
module cache_byte_valid_ctrl #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned WAYS       = 4,
   parameter int unsigned WORD_BYTES = 4
) (
   input logic                   clk,
   input logic                   rst,
   cache_byte_valid_ctrl_if.slave bus
);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef logic [WAYS-1:0][WORD_BYTES-1:0] row_t;
   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sweepCnt_q, sweepCnt_d;
   logic                  invDone_q, invDone_d;
   logic                  busy, invAcc, rdAcc, updAcc, sweepWr;

   row_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StSweep;
         sweepCnt_q <= '0;
         invDone_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
         invDone_q  <= invDone_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sweepCnt_d = sweepCnt_q;
      invDone_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.inv_req) begin
               state_d    = StSweep;
               sweepCnt_d = '0;
            end
         end
         StSweep: begin
            sweepCnt_d = sweepCnt_q + 1'b1;
            if (sweepCnt_q == '1) begin
               state_d   = StIdle;
               invDone_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy         = (state_q == StSweep);
      sweepWr      = busy;
      invAcc       = (state_q == StIdle) && bus.inv_req;
      rdAcc        = bus.rd_en && !busy && !invAcc && !rst;
      updAcc       = bus.upd_en && !busy && !invAcc && !rst;
      bus.busy     = busy;
      bus.inv_done = invDone_q;
   end

   // Update pipeline: old way value captured at accept, merged and written next cycle.
   logic                  updPend_q;
   logic [ADDR_WIDTH-1:0] updAddr_q;
   logic [WAY_W-1:0]      updWay_q;
   logic [WORD_BYTES-1:0] updMask_q, updOld_q, updNew;
   logic                  updClr_q;

   logic [WAYS-1:0]       wrWayEn;
   logic [ADDR_WIDTH-1:0] wrAddr;
   row_t                  wrRow, rdRow, updRow;

   always_comb begin
      updNew  = updClr_q ? updMask_q : (updOld_q | updMask_q);
      wrWayEn = '0;
      wrAddr  = '0;
      wrRow   = '0;
      if (sweepWr) begin
         wrWayEn = '1;
         wrAddr  = sweepCnt_q;
      end else if (updPend_q && !rst) begin
         wrWayEn[updWay_q] = 1'b1;
         wrAddr            = updAddr_q;
         wrRow[updWay_q]   = updNew;
      end
   end

   // The write landing this cycle is forwarded so both read paths see post-write data.
   always_comb begin
      rdRow  = mem[bus.rd_addr];
      updRow = mem[bus.upd_addr];
      for (int w = 0; w < WAYS; w++) begin
         if (wrWayEn[w] && (wrAddr == bus.rd_addr))  rdRow[w]  = wrRow[w];
         if (wrWayEn[w] && (wrAddr == bus.upd_addr)) updRow[w] = wrRow[w];
      end
   end

   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (wrWayEn[w]) mem[wrAddr][w] <= wrRow[w];
      end
   end

   logic                  rdValid_q;
   logic [WORD_BYTES-1:0] rdMask_q;
   row_t                  rdMaskAll_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdValid_q   <= 1'b0;
         rdMask_q    <= '0;
         rdMaskAll_q <= '0;
         updPend_q   <= 1'b0;
      end else begin
         rdValid_q <= rdAcc;
         updPend_q <= updAcc;
         if (rdAcc) begin
            rdMask_q    <= rdRow[bus.rd_way];
            rdMaskAll_q <= rdRow;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (updAcc) begin
         updAddr_q <= bus.upd_addr;
         updWay_q  <= bus.upd_way;
         updMask_q <= bus.upd_mask;
         updClr_q  <= bus.upd_clr;
         updOld_q  <= updRow[bus.upd_way];
      end
   end

   always_comb begin
      bus.rd_valid    = rdValid_q;
      bus.rd_mask     = rdMask_q;
      bus.rd_mask_all = rdMaskAll_q;
   end
endmodule
